// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcode encodings, FSM state
// type and a small opcode classifier. Imported by alu_sequencer and alu_cmd_fifo.
package alu_sequencer_pkg;

  localparam int unsigned OpW = 4;

  localparam logic [OpW-1:0] OP_LOAD = 4'd0;
  localparam logic [OpW-1:0] OP_ADD  = 4'd1;
  localparam logic [OpW-1:0] OP_SUB  = 4'd2;
  localparam logic [OpW-1:0] OP_MUL  = 4'd3;
  localparam logic [OpW-1:0] OP_DIV  = 4'd4;
  localparam logic [OpW-1:0] OP_INV  = 4'd5;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait
  } seq_state_e;

  // Opcodes that need an ALU round trip; LOAD and 6..15 retire in FETCH.
  function automatic logic is_alu_op(input logic [OpW-1:0] op);
    return (op >= OP_ADD) && (op <= OP_INV);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command buffer for the ALU sequencer.
//  clock, reset_n : rising-edge clock, synchronous active-low reset
//  flush          : synchronous clear of all entries (wins over push)
//  push / wdata   : write one entry; accepted when not full or when popping
//  pop / rdata    : rdata shows the head entry; pop removes it
//  full, empty    : occupancy flags
//  count          : number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = DEPTH[PtrW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [PtrW:0]    count_q;
  logic [PtrW:0]    count_d;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign pop_en  = pop & ~empty;
  // A full buffer still takes a write when the head leaves in the same cycle.
  assign push_en = push & (~full | pop_en);

  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) mem_q[wptr_q] <= wdata;
  end

  assign rdata = mem_q[rptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_sequencer.sv
// Command-stream initiator for the ALU. Buffers (opcode, operand) pairs, issues
// them to the ALU one at a time and keeps the running accumulator, writing each
// ALU result back as the accumulator seen by the next command.
//  clock, reset_n           : rising-edge clock, synchronous active-low reset
//  cmd_valid/cmd_ready      : front-end handshake, cmd_op + cmd_operand payload
//  alu_enable               : one-cycle ALU strobe (ISSUE state only)
//  alu_cmd/alu_acc/alu_operand : ALU inputs, held from ISSUE through WAIT
//  alu_out                  : ALU result, valid ALU_LAT clocks after alu_enable
//  acc                      : architectural accumulator
//  done                     : one-cycle pulse per retired command, aligned with
//                             the cycle in which acc already shows its result
//  busy                     : commands buffered or FSM not idle
//  div_err (optional)       : sticky divide-by-zero flag
// Build option: define ALU_SEQ_DIVZERO_TRAP_EN to trap DIV by zero instead of
// issuing it; the trap flushes the buffer, keeps acc and sets div_err.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ALU_LAT    = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic             alu_enable,
  output logic [3:0]       alu_cmd,
  output logic [WIDTH-1:0] alu_acc,
  output logic [WIDTH-1:0] alu_operand,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] acc,
  output logic             done,
  output logic             busy
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  ,
  output logic             div_err
`endif
);

  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0]  LastCnt  = 3'(ALU_LAT - 1);

  seq_state_e        state_q, state_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [WIDTH-1:0]  operand_q, operand_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              done_q, done_d;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_flush;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FifoCntW-1:0]  fifo_count;
  logic [WIDTH+3:0]     fifo_rdata;
  logic [3:0]           head_op;
  logic [WIDTH-1:0]     head_operand;
  logic                 more_after_pop;
  logic                 div_trap;

  assign cmd_ready    = ~fifo_full;
  assign fifo_push    = cmd_valid & cmd_ready;
  assign head_op      = fifo_rdata[WIDTH+3:WIDTH];
  assign head_operand = fifo_rdata[WIDTH-1:0];
  // Something is still queued once the head leaves (including this cycle's push).
  assign more_after_pop = (fifo_count > FifoCntW'(1)) | fifo_push;

`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  assign div_trap = (head_op == OP_DIV) && (head_operand == '0);
`else
  assign div_trap = 1'b0;
`endif

  alu_cmd_fifo #(
    .WIDTH (WIDTH + 4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   ({cmd_op, cmd_operand}),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    operand_d  = operand_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StFetch;
      end
      StFetch: begin
        fifo_pop  = 1'b1;
        cmd_d     = head_op;
        operand_d = head_operand;
        if (div_trap) begin
          fifo_flush = 1'b1;
          done_d     = 1'b1;
          state_d    = StIdle;
        end else if (is_alu_op(head_op)) begin
          state_d = StIssue;
        end else begin
          if (head_op == OP_LOAD) acc_d = head_operand;
          done_d  = 1'b1;
          state_d = more_after_pop ? StFetch : StIdle;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == LastCnt) begin
          acc_d   = alu_out;
          done_d  = 1'b1;
          state_d = (!fifo_empty || fifo_push) ? StFetch : StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      operand_q <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  logic div_err_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_err_q <= 1'b0;
    end else if ((state_q == StFetch) && div_trap) begin
      div_err_q <= 1'b1;
    end
  end

  assign div_err = div_err_q;
`endif

  // ALU inputs come straight from registers, so they cannot move between
  // ISSUE and the retiring WAIT cycle.
  assign alu_enable  = (state_q == StIssue);
  assign alu_cmd     = cmd_q;
  assign alu_acc     = acc_q;
  assign alu_operand = operand_q;
  assign acc         = acc_q;
  assign done        = done_q;
  assign busy        = ~fifo_empty | (state_q != StIdle);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam int unsigned W       = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ALU_LAT = 3;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_op = '0;
  logic [W-1:0] cmd_operand = '0;
  logic         alu_enable;
  logic [3:0]   alu_cmd;
  logic [W-1:0] alu_acc;
  logic [W-1:0] alu_operand;
  logic [W-1:0] alu_out;
  logic [W-1:0] acc;
  logic         done;
  logic         busy;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
  logic         div_err;
`endif

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  alu_sequencer #(
    .WIDTH      (W),
    .FIFO_DEPTH (DEPTH),
    .ALU_LAT    (ALU_LAT)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_operand (cmd_operand),
    .alu_enable  (alu_enable),
    .alu_cmd     (alu_cmd),
    .alu_acc     (alu_acc),
    .alu_operand (alu_operand),
    .alu_out     (alu_out),
    .acc         (acc),
    .done        (done),
    .busy        (busy)
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    ,
    .div_err     (div_err)
`endif
  );

  // Behavioural ALU: arithmetic on the enable edge, result delayed ALU_LAT clocks.
  function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      4'd1:    return a + b;
      4'd2:    return a - b;
      4'd3:    return a * b;
      4'd4:    return (b == 0) ? {W{1'b1}} : W'($signed(a) / $signed(b));
      4'd5:    return ~a;
      default: return 16'hDEAD;
    endcase
  endfunction

  logic [W-1:0] alu_pipe [ALU_LAT];
  always @(posedge clock) begin
    alu_pipe[0] <= alu_enable ? alu_f(alu_cmd, alu_acc, alu_operand) : 16'hDEAD;
    for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_out = alu_pipe[ALU_LAT-1];

  // Reference model: architectural effect of one command on the accumulator.
  function automatic logic [W-1:0] model_next(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    if (op == 4'd0) return b;
    if (op >= 4'd1 && op <= 4'd5) return alu_f(op, a, b);
    return a;
  endfunction

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] val;
  } cmd_t;

  cmd_t         exp_q[$];
  logic [W-1:0] model_acc = '0;
  int           done_cnt = 0;
  int           done_run = 0;
  int           max_run = 0;
  int           hold = 0;
  logic         prev_en = 1'b0;
  logic [3:0]   h_cmd;
  logic [W-1:0] h_acc;
  logic [W-1:0] h_opnd;

  // Scoreboard: accepted commands retire in order with the model's accumulator.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      model_acc = '0;
      hold      = 0;
      prev_en   = 1'b0;
      done_run  = 0;
    end else begin
      if (hold > 0) begin
        total++;
        if (alu_cmd !== h_cmd || alu_acc !== h_acc || alu_operand !== h_opnd) begin
          bad++;
          $display("FAIL alu_hold: got cmd=%0d acc=%h opnd=%h, need cmd=%0d acc=%h opnd=%h",
                   alu_cmd, alu_acc, alu_operand, h_cmd, h_acc, h_opnd);
        end
        hold--;
      end
      if (alu_enable) begin
        total++;
        if (prev_en) begin
          bad++;
          $display("FAIL alu_enable_width: enable high 2 cycles in a row, need 1");
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL alu_issue: enable with no queued command");
        end else if (alu_cmd !== exp_q[0].op || alu_acc !== model_acc ||
                     alu_operand !== exp_q[0].val) begin
          bad++;
          $display("FAIL alu_issue: got cmd=%0d acc=%h opnd=%h, need cmd=%0d acc=%h opnd=%h",
                   alu_cmd, alu_acc, alu_operand, exp_q[0].op, model_acc, exp_q[0].val);
        end
        hold   = ALU_LAT;
        h_cmd  = alu_cmd;
        h_acc  = alu_acc;
        h_opnd = alu_operand;
      end
      prev_en = alu_enable;
      if (done) begin
        done_cnt++;
        done_run++;
        if (done_run > max_run) max_run = done_run;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_done: done=1 with nothing outstanding");
        end else begin
          cmd_t c;
          logic trap;
          c = exp_q.pop_front();
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
          trap = (c.op == 4'd4) && (c.val == '0);
`else
          trap = 1'b0;
`endif
          if (trap) exp_q.delete();
          else model_acc = model_next(c.op, model_acc, c.val);
          if (acc !== model_acc) begin
            bad++;
            $display("FAIL acc_retire: op=%0d got acc=%h need %h", c.op, acc, model_acc);
          end
        end
      end else begin
        done_run = 0;
      end
      if (cmd_valid && cmd_ready) exp_q.push_back('{op: cmd_op, val: cmd_operand});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer one command; returns with valid dropped one cycle after the transfer.
  task automatic push(input logic [3:0] op, input logic [W-1:0] val, output bit stalled);
    int g;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = val;
    stalled     = 1'b0;
    g           = 0;
    @(negedge clock);
    while (!cmd_ready) begin
      stalled = 1'b1;
      g++;
      if (g > 500) begin
        total++;
        bad++;
        $display("FAIL push_timeout: cmd_ready=0 for 500 cycles, need 1");
        break;
      end
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy) begin
      tick();
      g++;
      if (g > 300) begin
        total++;
        bad++;
        $display("FAIL idle_timeout: busy=1 after 300 cycles, need 0");
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    total++;
    if ({acc, alu_acc, alu_operand} !== '0 || alu_cmd !== 4'd0) begin
      bad++;
      $display("FAIL reset_data: acc=%h alu_acc=%h alu_opnd=%h alu_cmd=%0d, need 0",
               acc, alu_acc, alu_operand, alu_cmd);
    end
    total++;
    if ({alu_enable, done, busy, cmd_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL reset_ctrl: en/done/busy/ready=%b, need 0001",
               {alu_enable, done, busy, cmd_ready});
    end
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    total++;
    if (div_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_div_err: got %b need 0", div_err);
    end
`endif
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    bit s;
    int d0;
    d0 = done_cnt;
    push(4'd0, 16'd50, s);
    push(4'd1, 16'd32, s);
    push(4'd2, 16'd5, s);
    push(4'd3, 16'd9, s);
    wait_idle();
    total++;
    if (acc !== 16'd693 || done_cnt - d0 != 4) begin
      bad++;
      $display("FAIL directed_mul: acc=%0d dones=%0d, need 693 and 4", acc, done_cnt - d0);
    end
    push(4'd4, 16'd4, s);
    wait_idle();
    total++;
    if (acc !== 16'd173) begin
      bad++;
      $display("FAIL directed_div: acc=%0d need 173", acc);
    end
    push(4'd5, 16'd0, s);
    wait_idle();
    total++;
    if (acc !== 16'hFF52 || done_cnt - d0 != 6) begin
      bad++;
      $display("FAIL directed_inv: acc=%h dones=%0d, need ff52 and 6", acc, done_cnt - d0);
    end
  endtask

  task automatic test_latency();
    bit s;
    int en_k;
    int hit_k;
    push(4'd0, 16'd10, s);
    wait_idle();
    push(4'd1, 16'd7, s);
    en_k  = 0;
    hit_k = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (alu_enable && en_k == 0) en_k = k;
      if (acc === 16'd17) begin
        hit_k = k;
        break;
      end
    end
    total++;
    if (en_k != 3) begin
      bad++;
      $display("FAIL issue_cycle: enable at cycle %0d, need 3", en_k);
    end
    total++;
    if (hit_k != ALU_LAT + 4) begin
      bad++;
      $display("FAIL acc_latency: acc=17 at cycle %0d, need %0d", hit_k, ALU_LAT + 4);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    bit s;
    logic [W-1:0] v;
    max_run = 0;
    for (int i = 0; i < 4; i++) begin
      v = W'($urandom);
      push(4'd0, v, s);
    end
    wait_idle();
    total++;
    if (max_run != 4 || acc !== v) begin
      bad++;
      $display("FAIL load_rate: run=%0d acc=%h, need 4 consecutive and acc=%h", max_run, acc, v);
    end
  endtask

  task automatic test_backpressure();
    bit s;
    int first_stall;
    int d0;
    logic [W-1:0] exp;
    logic [W-1:0] v;
    d0          = done_cnt;
    first_stall = -1;
    exp         = acc;
    for (int i = 0; i < 6; i++) begin
      v   = W'($urandom_range(1000, 1));
      exp = exp + v;
      push(4'd1, v, s);
      if (s && first_stall < 0) first_stall = i;
    end
    wait_idle();
    total++;
    if (first_stall < 4 || first_stall > 5) begin
      bad++;
      $display("FAIL ready_drop: accepts before stall=%0d, need 4 or 5", first_stall);
    end
    total++;
    if (acc !== exp || done_cnt - d0 != 6) begin
      bad++;
      $display("FAIL burst_retire: acc=%h dones=%0d, need %h and 6", acc, done_cnt - d0, exp);
    end
  endtask

  task automatic test_random();
    bit s;
    int d0;
    logic [3:0] op;
    logic [W-1:0] v;
    d0 = done_cnt;
    for (int i = 0; i < 24; i++) begin
      op = 4'($urandom_range(15, 0));
      v  = W'($urandom);
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
      if (op == 4'd4 && v == '0) v = 16'd1;
`endif
      push(op, v, s);
      repeat ($urandom_range(3, 0)) tick();
    end
    wait_idle();
    total++;
    if (acc !== model_acc || done_cnt - d0 != 24) begin
      bad++;
      $display("FAIL random_final: acc=%h dones=%0d, need %h and 24", acc, done_cnt - d0,
               model_acc);
    end
  endtask

  task automatic test_reset_mid();
    bit s;
    int d0;
    push(4'd0, 16'd5, s);
    wait_idle();
    push(4'd3, 16'd3, s);
    push(4'd1, 16'd1, s);
    tick();
    tick();
    total++;
    if (busy !== 1'b1 || alu_enable !== 1'b0) begin
      bad++;
      $display("FAIL pre_reset: busy=%b en=%b, need busy=1 en=0", busy, alu_enable);
    end
    d0      = done_cnt;
    reset_n = 1'b0;
    tick();
    total++;
    if ({acc, alu_acc, alu_operand} !== '0 || alu_cmd !== 4'd0 ||
        {alu_enable, done, busy, cmd_ready} !== 4'b0001) begin
      bad++;
      $display("FAIL mid_reset: acc=%h alu_cmd=%0d en/done/busy/ready=%b, need 0 and 0001",
               acc, alu_cmd, {alu_enable, done, busy, cmd_ready});
    end
    reset_n = 1'b1;
    repeat (10) tick();
    total++;
    if (done_cnt != d0 || busy !== 1'b0 || acc !== '0) begin
      bad++;
      $display("FAIL post_reset: dones=%0d busy=%b acc=%h, need 0, 0, 0", done_cnt - d0,
               busy, acc);
    end
  endtask

  task automatic test_div_zero();
    bit s;
    int d0;
    d0 = done_cnt;
    push(4'd0, 16'd100, s);
    push(4'd3, 16'd3, s);
    push(4'd4, 16'd0, s);
    push(4'd1, 16'd1, s);
    push(4'd1, 16'd2, s);
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    wait_idle();
    total++;
    if (div_err !== 1'b1 || acc !== 16'd300 || done_cnt - d0 != 3) begin
      bad++;
      $display("FAIL div_trap: div_err=%b acc=%0d dones=%0d, need 1, 300, 3", div_err, acc,
               done_cnt - d0);
    end
`else
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
        @(negedge clock);
        if (alu_enable && alu_cmd == 4'd4) begin
          seen = 1'b1;
          total++;
          if (alu_operand !== '0 || alu_acc !== 16'd300) begin
            bad++;
            $display("FAIL div0_issue: opnd=%h acc=%h, need 0 and 012c", alu_operand, alu_acc);
          end
        end
      end
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL div0_issue: DIV never issued within 60 cycles");
      end
    end
    tick();
    wait_idle();
    total++;
    if (acc !== 16'd2 || done_cnt - d0 != 5) begin
      bad++;
      $display("FAIL div0_final: acc=%h dones=%0d, need 0002 and 5", acc, done_cnt - d0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_div_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
